mem_arbiter: RTL

- Round-robin arbiter sharing one single-port memory between NUM_REQ requesters, for example a CPU core and a NoC DMA engine.
- Drives the memory side of the memory interface (data_in, addr_in, wb_in, enable_in out; data_out in) and serialises accesses: one transaction in flight at a time.
- Each requester gets a valid/ready request channel and a response strobe.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arbiter_rr_picker.sv | 30 +++
 rtl/mem_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory arbiter and its round-robin picker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arb_pkg;

   localparam int BYTE_LANES = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      CAPTURE = 2'd2
   } arb_state_e;

   // Width of a requester index; a single requester still needs one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Rotating priority encoder: first asserted req strictly after 'last', with wrap-around.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is consumed.
module rr_picker #(
   parameter int N  = 2,
   parameter int IW = 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic          found,
   output logic [IW-1:0] idx
);

   int cand;

   // Walk candidates last+1 .. last+N (mod N); the first active one wins.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = 0;
      for (int k = 1; k <= N; k++) begin
         cand = (int'(last) + k) % N;
         if (!found && req[cand[IW-1:0]]) begin
            found = 1'b1;
            idx   = cand[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory; one transaction in flight at a time.
// Latency: response strobe 2 cycles after handshake for writes, 3 cycles for reads.
// Backpressure: req_ready only in IDLE, one-hot to the round-robin winner; requesters hold until ready.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MEMORY_BUS_WIDTH = 32,
   parameter int NUM_REQ          = 2,
   localparam int AW = MEMORY_BUS_WIDTH - 2,
   localparam int IW = idx_width(NUM_REQ)
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [NUM_REQ-1:0]               req_valid,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic [NUM_REQ*AW-1:0]            req_addr,
   input  logic [NUM_REQ*MEMORY_BUS_WIDTH-1:0] req_wdata,
   input  logic [NUM_REQ*BYTE_LANES-1:0]    req_wb,
   output logic [NUM_REQ-1:0]               rsp_valid,
   output logic [MEMORY_BUS_WIDTH-1:0]      rsp_rdata,
   output logic [MEMORY_BUS_WIDTH-1:0]      mem_data_in,
   output logic [AW-1:0]                    mem_addr_in,
   output logic [BYTE_LANES-1:0]            mem_wb_in,
   output logic                             mem_enable_in,
   input  logic [MEMORY_BUS_WIDTH-1:0]      mem_data_out,
   output logic                             busy,
   output logic [IW-1:0]                    grant_id
);

   arb_state_e                  state_q, state_d;
   logic [IW-1:0]               last_q, last_d;
   logic [IW-1:0]               gid_q, gid_d;
   logic [AW-1:0]               addr_q, addr_d;
   logic [MEMORY_BUS_WIDTH-1:0] wdata_q, wdata_d;
   logic [MEMORY_BUS_WIDTH-1:0] rdata_q, rdata_d;
   logic [BYTE_LANES-1:0]       wb_q, wb_d;
   logic [NUM_REQ-1:0]          rsp_q, rsp_d;
   logic                        pick_found;
   logic [IW-1:0]               pick_idx;

   rr_picker #(.N(NUM_REQ), .IW(IW)) u_pick (
      .req   (req_valid),
      .last  (last_q),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Next-state, request capture and memory-side drive for the three-state access FSM.
   always_comb begin
      state_d       = state_q;
      last_d        = last_q;
      gid_d         = gid_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      wb_d          = wb_q;
      rdata_d       = rdata_q;
      rsp_d         = '0;
      req_ready     = '0;
      mem_enable_in = 1'b0;
      mem_addr_in   = '0;
      mem_data_in   = '0;
      mem_wb_in     = '0;
      case (state_q)
         IDLE: begin
            // reset gating keeps req_ready low while the block is held in reset
            if (pick_found && reset) begin
               req_ready[pick_idx] = 1'b1;
               addr_d  = req_addr[int'(pick_idx)*AW +: AW];
               wdata_d = req_wdata[int'(pick_idx)*MEMORY_BUS_WIDTH +: MEMORY_BUS_WIDTH];
               wb_d    = req_wb[int'(pick_idx)*BYTE_LANES +: BYTE_LANES];
               last_d  = pick_idx;
               gid_d   = pick_idx;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            mem_enable_in = 1'b1;
            mem_addr_in   = addr_q;
            mem_data_in   = wdata_q;
            mem_wb_in     = wb_q;
            if (wb_q != '0) begin
               // write lands on this edge, so it can complete immediately
               rsp_d[gid_q] = 1'b1;
               rdata_d      = '0;
               state_d      = IDLE;
            end else begin
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            rdata_d      = mem_data_out;
            rsp_d[gid_q] = 1'b1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any access in flight.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         last_q  <= IW'(NUM_REQ - 1);
         gid_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         wb_q    <= '0;
         rdata_q <= '0;
         rsp_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         gid_q   <= gid_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wb_q    <= wb_d;
         rdata_q <= rdata_d;
         rsp_q   <= rsp_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign rsp_valid = rsp_q;
   assign rsp_rdata = rdata_q;
   assign grant_id  = gid_q;

endmodule
